// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// Inputs are double-buffered and committed on frame boundaries; each digit slot starts with a dark guard interval.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    hex_en,
    input  logic                    lz_en,
    output logic                    busy,
    output logic                    frame_done,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_data,  r_pend_data;
    logic [NUM_DIGITS-1:0]   r_act_dp,    r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
    logic                    r_busy;
    logic                    r_frame_done;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic [NUM_DIGITS-1:0]   r_an_n;

    logic                    w_wrap;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_supp;
    logic                    w_lead;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_dark;
    logic [NUM_DIGITS-1:0]   w_an_sel;

    function automatic logic [6:0] f_glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b000_0001;
            4'h1: g = 7'b100_1111;
            4'h2: g = 7'b001_0010;
            4'h3: g = 7'b000_0110;
            4'h4: g = 7'b100_1100;
            4'h5: g = 7'b010_0100;
            4'h6: g = 7'b010_0000;
            4'h7: g = 7'b000_1111;
            4'h8: g = 7'b000_0000;
            4'h9: g = 7'b000_1100;
            4'hA: g = hex ? 7'b000_1000 : 7'h7F;
            4'hB: g = hex ? 7'b110_0000 : 7'h7F;
            4'hC: g = hex ? 7'b011_0001 : 7'h7F;
            4'hD: g = hex ? 7'b100_0010 : 7'h7F;
            4'hE: g = hex ? 7'b011_0000 : 7'h7F;
            default: g = hex ? 7'b011_1000 : 7'h7F;
        endcase
        return g;
    endfunction

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_boundary = w_wrap && (r_idx == IDX_LAST);

    // Walk down from the top digit; suppression stops at the first nonzero nibble.
    always_comb begin
        w_supp = '0;
        w_lead = lz_en;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (w_lead && (r_act_data[4*k +: 4] == 4'd0)) begin
                w_supp[k] = 1'b1;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    always_comb begin
        w_nib    = '0;
        w_dp     = 1'b0;
        w_dark   = 1'b0;
        w_an_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_act_data[4*k +: 4];
                w_dp        = r_act_dp[k];
                w_dark      = r_act_blank[k] | w_supp[k];
                w_an_sel[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg_n      <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            r_frame_done <= w_boundary;

            // A load landing on the boundary bypasses pending entirely.
            if (load && w_boundary) begin
                r_act_data  <= data_in;
                r_act_dp    <= dp_in;
                r_act_blank <= blank_in;
                r_busy      <= 1'b0;
            end else if (load) begin
                r_pend_data  <= data_in;
                r_pend_dp    <= dp_in;
                r_pend_blank <= blank_in;
                r_busy       <= 1'b1;
            end else if (w_boundary && r_busy) begin
                r_act_data  <= r_pend_data;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_busy      <= 1'b0;
            end

            if (r_cnt < CNT_BLANK) begin
                r_an_n  <= '1;
                r_seg_n <= 7'h7F;
                r_dp_n  <= 1'b1;
            end else begin
                r_an_n  <= ~w_an_sel;
                r_seg_n <= w_dark ? 7'h7F : f_glyph(w_nib, hex_en);
                r_dp_n  <= w_dark ? 1'b1 : ~w_dp;
            end
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: cycle-accurate reference model plus hand-computed scenario checks.
module tb_seven_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   data_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic          hex_en = 1'b1;
    logic          lz_en = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n;

    int nchecks = 0;
    int nerrors = 0;
    bit chk_en  = 1'b0;

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .hex_en(hex_en), .lz_en(lz_en),
        .busy(busy), .frame_done(frame_done), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    logic [6:0] GLYPH [16] = '{
        7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
        7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
        7'b000_0000, 7'b000_1100, 7'b000_1000, 7'b110_0000,
        7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
    };

    // Reference model: position in the scan is derived from elapsed cycles since reset.
    int         m_t = 0;
    logic [15:0] m_act_data = '0, m_pend_data = '0;
    logic [3:0]  m_act_dp = '0, m_pend_dp = '0, m_act_bl = '0, m_pend_bl = '0;
    logic        m_busy = 1'b0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp = 1'b1;
    logic        exp_fd = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        int cnt, idx, v;
        bit bnd, dark;
        if (!reset_n) begin
            m_t = 0;
            m_act_data = '0; m_pend_data = '0;
            m_act_dp = '0; m_pend_dp = '0; m_act_bl = '0; m_pend_bl = '0;
            m_busy = 1'b0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            cnt  = m_t % RD;
            idx  = (m_t / RD) % ND;
            bnd  = (cnt == RD - 1) && (idx == ND - 1);
            v    = int'((m_act_data >> (4 * idx)) & 16'hF);
            dark = m_act_bl[idx] || (lz_en && idx > 0 && (m_act_data >> (4 * idx)) == 16'h0);
            if (cnt < BC) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = 4'hF;
                exp_an[idx] = 1'b0;
                if (dark)                   exp_seg = 7'h7F;
                else if (v < 10 || hex_en)  exp_seg = GLYPH[v];
                else                        exp_seg = 7'h7F;
                exp_dp = dark ? 1'b1 : ~m_act_dp[idx];
            end
            exp_fd = bnd;
            if (load && bnd) begin
                m_act_data = data_in; m_act_dp = dp_in; m_act_bl = blank_in; m_busy = 1'b0;
            end else if (load) begin
                m_pend_data = data_in; m_pend_dp = dp_in; m_pend_bl = blank_in; m_busy = 1'b1;
            end else if (bnd && m_busy) begin
                m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl; m_busy = 1'b0;
            end
            m_t++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nchecks++;
        if (act !== expv) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_an",   32'(an_n),       32'(exp_an));
            chk("model_seg",  32'(seg_n),      32'(exp_seg));
            chk("model_dp",   32'(dp_n),       32'(exp_dp));
            chk("model_fd",   32'(frame_done), 32'(exp_fd));
            chk("model_busy", 32'(busy),       32'(m_busy));
        end
    end

    task automatic wait_an(input logic [3:0] pat);
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (an_n == pat) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_an_timeout", 32'(an_n), 32'(pat));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Returns at the negedge where the next posedge will process frame cycle `phase`.
    task automatic wait_phase(input int phase);
        bit ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (m_t % FRAME == phase) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_phase_timeout", 32'(m_t % FRAME), 32'(phase));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_an", 32'(an_n), 32'hF);
        chk("reset_seg", 32'(seg_n), 32'h7F);
        reset_n = 1'b1;

        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i <= 2) chk("post_reset_dark", 32'(an_n), 32'hF);
            if (i == 3) begin
                chk("first_digit_an", 32'(an_n), 32'hE);
                chk("first_digit_seg", 32'(seg_n), 32'b000_0001);
            end
            if (i == 11) chk("step_an_D", 32'(an_n), 32'hD);
            if (i == 19) chk("step_an_B", 32'(an_n), 32'hB);
            if (i == 27) chk("step_an_7", 32'(an_n), 32'h7);
            if (i == 31) chk("fd_before", 32'(frame_done), 32'd0);
            if (i == 32) chk("fd_pulse", 32'(frame_done), 32'd1);
            if (i == 33) chk("fd_after", 32'(frame_done), 32'd0);
        end

        wait_phase(10);
        do_load(16'h12AF, 4'h0, 4'h0);
        chk("busy_after_load", 32'(busy), 32'd1);
        wait_idle();
        wait_an(4'hE); chk("hex_F", 32'(seg_n), 32'b011_1000);
        wait_an(4'hD); chk("hex_A", 32'(seg_n), 32'b000_1000);
        wait_an(4'hB); chk("hex_2", 32'(seg_n), 32'b001_0010);
        wait_an(4'h7); chk("hex_1", 32'(seg_n), 32'b100_1111);

        hex_en = 1'b0;
        wait_an(4'hE); chk("nohex_d0", 32'(seg_n), 32'h7F);
        wait_an(4'hD); chk("nohex_d1", 32'(seg_n), 32'h7F);
        hex_en = 1'b1;

        lz_en = 1'b1;
        wait_phase(10);
        do_load(16'h0030, 4'h0, 4'h0);
        wait_idle();
        wait_an(4'hE); chk("lz_d0", 32'(seg_n), 32'b000_0001);
        wait_an(4'hD); chk("lz_d1", 32'(seg_n), 32'b000_0110);
        wait_an(4'hB); chk("lz_d2", 32'(seg_n), 32'h7F);
        wait_an(4'h7); chk("lz_d3", 32'(seg_n), 32'h7F);
        wait_phase(10);
        do_load(16'h0000, 4'h0, 4'h0);
        wait_idle();
        wait_an(4'hE); chk("lz0_d0", 32'(seg_n), 32'b000_0001);
        wait_an(4'hD); chk("lz0_d1", 32'(seg_n), 32'h7F);
        lz_en = 1'b0;

        wait_phase(3);
        do_load(16'h1111, 4'h0, 4'h0);
        do_load(16'h2222, 4'h0, 4'h0);
        wait_idle();
        wait_an(4'hE); chk("last_load_wins", 32'(seg_n), 32'b001_0010);

        wait_phase(FRAME - 1);
        do_load(16'h5555, 4'h0, 4'h0);
        chk("boundary_busy", 32'(busy), 32'd0);
        wait_an(4'hE); chk("boundary_show", 32'(seg_n), 32'b010_0100);

        wait_phase(10);
        do_load(16'h4321, 4'b0100, 4'b0001);
        wait_idle();
        wait_an(4'hE); chk("blank_seg", 32'(seg_n), 32'h7F); chk("blank_dp", 32'(dp_n), 32'd1);
        wait_an(4'hD); chk("dp_off_d1", 32'(dp_n), 32'd1);
        wait_an(4'hB); chk("dp_on_d2", 32'(dp_n), 32'd0); chk("d2_seg", 32'(seg_n), 32'b000_0110);
        wait_an(4'h7); chk("dp_off_d3", 32'(dp_n), 32'd1);

        wait_phase(12);
        do_load(16'h9999, 4'h0, 4'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_an", 32'(an_n), 32'hF);
        chk("async_seg", 32'(seg_n), 32'h7F);
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_an(4'hE); chk("pending_lost", 32'(seg_n), 32'b000_0001);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                for (int k = 0; k < 4; k++)
                    data_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_in = 4'($urandom);
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 63) == 0) hex_en = ~hex_en;
            if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
            if ($urandom_range(0, 1499) == 0) begin
                #3 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end
        load = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Accepts one packed nibble per digit and supports hex or decimal glyphs, per-digit blanking, decimal points and leading-zero suppression.
- Scans one digit at a time, with a blanking guard between digits to suppress ghosting.
- New values are double-buffered and committed only at frame boundaries, so the display never tears.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes (>=1)
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous active-low reset
- data_in  in  4*NUM_DIGITS  packed nibbles; digit k = data_in[4k+3:4k]; digit 0 is rightmost/least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- blank_in  in  NUM_DIGITS  per-digit force-blank, 1 = dark
- load  in  1  single-cycle strobe capturing data_in/dp_in/blank_in
- hex_en  in  1  1 = hex glyphs for 10..15; 0 = 10..15 shown dark
- lz_en  in  1  1 = leading-zero suppression
- busy  out  1  a load is pending commit
- frame_done  out  1  one-cycle pulse when the last digit slot ends
- seg_n  out  7  segments abc_defg, seg_n[6]=a .. seg_n[0]=g, active-low
- dp_n  out  1  decimal point, active-low
- an_n  out  NUM_DIGITS  anode enables, active-low, at most one low

Behaviour:
- Async reset (reset_n=0) forces:
  - slot counter = 0, digit index = 0
  - active and pending registers = 0, busy = 0, frame_done = 0
  - seg_n = 7'h7F, dp_n = 1, an_n = all ones
- Slot counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index advances by 1, wrapping NUM_DIGITS-1 -> 0.
  - A frame boundary is a wrap while index = NUM_DIGITS-1.
  - frame_done is registered high in the cycle after the boundary.
- Double buffer:
  - load=1 captures the inputs into pending and sets busy.
  - A second load while busy overwrites pending; last one wins.
  - At a frame boundary with busy=1, pending copies to active and busy clears.
  - If load and the frame boundary fall in the same cycle, the new inputs go directly to active and busy stays 0.
- Leading-zero suppression, when lz_en=1:
  - Digit k is suppressed if its active nibble is 0 and every higher digit is 0 or suppressed.
  - Digit 0 is never suppressed.
  - Nibbles 10..15 count as nonzero regardless of hex_en.
- Glyph table (seg_n, 1 = off):
  - 0 = 000_0001, 1 = 100_1111, 2 = 001_0010, 3 = 000_0110, 4 = 100_1100
  - 5 = 010_0100, 6 = 010_0000, 7 = 000_1111, 8 = 000_0000, 9 = 000_1100
  - A = 000_1000, b = 110_0000, C = 011_0001, d = 100_0010, E = 011_0000, F = 011_1000
  - Value >9 with hex_en=0 = 111_1111.
- Dark digits: a digit that is blanked (blank bit) or suppressed drives seg_n = 7'h7F and dp_n = 1, but its anode still scans.
- Otherwise dp_n = ~dp bit of the active digit.
- Output timing:
  - seg_n, dp_n and an_n are registered; the value in cycle t+1 reflects counter, index and active state in cycle t.
  - When counter < BLANK_CYCLES: an_n = all ones, seg_n = 7'h7F, dp_n = 1.
  - Otherwise: an_n[index] = 0 and seg_n/dp_n show that digit.
- hex_en and lz_en are sampled live, not buffered; a change takes effect within one cycle.
- Reset mid-frame: outputs dark immediately (async); scanning restarts at digit 0, counter 0; any pending load is lost.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset release, no load -> an_n=4'hF for 3 cycles, then an_n=4'hE with seg_n=000_0001. After 8 cycles per slot, an_n steps E, D, B, 7. frame_done pulses every 32 cycles.
- load data_in=16'h12AF, hex_en=1 mid-frame -> busy=1 until the boundary. The next frame shows F, A, 2, 1 (seg_n 011_1000, 000_1000, 001_0010, 100_1111) on an_n E, D, B, 7.
- Same data with hex_en=0 -> digits 0 and 1 show 111_1111 and their anodes still go low.
- data_in=16'h0030, lz_en=1 -> digits 3 and 2 dark, digit 1 shows 3, digit 0 shows 0. data_in=16'h0000 -> only digit 0 lit, showing 0.
- Two loads (16'h1111, then 16'h2222) in one frame -> 2222 is displayed; 1111 never appears. A load in the exact boundary cycle -> displayed that frame, busy stays 0.
- dp_in=4'b0100, blank_in=4'b0001 -> dp_n=0 only in digit 2's slot; digit 0 dark. Assert reset_n mid-slot -> an_n=4'hF within the same cycle.
